vc_credit_allocator: RTL and testbench

Per-output-port allocator for the NoC switch. It extends the single-channel output allocator with VC_N output virtual channels and credit-based flow control. A header flit first wins an output VC (VC allocation). Flits of all packets holding a VC then compete each cycle for the physical channel (switch allocation), gated by per-VC credits. It sits between the input buffers and the crossbar select of one output port.

---
 rtl/vc_credit_allocator.sv | 182 ++++++++++++++++++
 tb/tb_vc_credit_allocator.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_credit_allocator.sv
// Per-output-port VC + switch allocator with credit-based flow control.
// Optional credit error checking is enabled by defining VC_ALLOC_CREDIT_CHECK_EN.
module vc_credit_allocator #(
    parameter int unsigned IN_N         = 5,
    parameter int unsigned VC_N         = 2,
    parameter int unsigned CREDIT_DEPTH = 4,
    parameter int unsigned VC_IDW       = (VC_N > 1) ? $clog2(VC_N) : 1,
    parameter int unsigned CRED_W       = $clog2(CREDIT_DEPTH + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [IN_N-1:0]          req_i,
    input  logic [IN_N-1:0]          data_vld_i,
    input  logic [IN_N-1:0]          flit_is_tail_i,
    input  logic [VC_N-1:0]          credit_rtn_i,
    output logic [IN_N-1:0]          vc_grant_o,
    output logic [IN_N*VC_IDW-1:0]   vc_id_o,
    output logic [IN_N-1:0]          sel_o,
    output logic                     oc_vld_o,
    output logic [VC_IDW-1:0]        oc_vc_o,
    output logic [VC_N*CRED_W-1:0]   credit_cnt_o,
    output logic                     err_o
);

    localparam int unsigned IN_IDW = (IN_N > 1) ? $clog2(IN_N) : 1;
    localparam logic [CRED_W-1:0] CredMax = CRED_W'(CREDIT_DEPTH);
    localparam logic [IN_IDW-1:0] PtrLast = IN_IDW'(IN_N - 1);

    logic [VC_N-1:0]                 vc_busy_q, vc_busy_d;
    logic [IN_N-1:0]                 grant_q, grant_d;
    logic [IN_N-1:0][VC_IDW-1:0]     id_q, id_d;
    logic [VC_N-1:0][CRED_W-1:0]     cred_q, cred_d;
    logic [IN_IDW-1:0]               va_ptr_q, va_ptr_d;
    logic [IN_IDW-1:0]               sa_ptr_q, sa_ptr_d;

    logic [IN_N-1:0]                 va_cand, sa_cand, sel;
    logic                            va_found, free_found, sa_found;
    logic [IN_IDW-1:0]               va_win, sa_win;
    logic [VC_IDW-1:0]               free_vc, sa_vc;
    logic [VC_N-1:0]                 xfer_vc;

    // Index of the k-th position after ptr, wrapping at IN_N.
    function automatic logic [IN_IDW-1:0] rr_idx(input logic [IN_IDW-1:0] ptr,
                                                 input int unsigned k);
        logic [IN_IDW:0] sum;
        sum = {1'b0, ptr} + (IN_IDW+1)'(k);
        if (sum >= (IN_IDW+1)'(IN_N)) sum = sum - (IN_IDW+1)'(IN_N);
        return sum[IN_IDW-1:0];
    endfunction

    function automatic logic [IN_IDW-1:0] ptr_inc(input logic [IN_IDW-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        va_cand    = req_i & data_vld_i & ~grant_q;
        va_found   = 1'b0;
        va_win     = '0;
        for (int unsigned k = 0; k < IN_N; k++) begin
            if (!va_found && va_cand[rr_idx(va_ptr_q, k)]) begin
                va_found = 1'b1;
                va_win   = rr_idx(va_ptr_q, k);
            end
        end
        free_found = 1'b0;
        free_vc    = '0;
        for (int unsigned v = 0; v < VC_N; v++) begin
            if (!free_found && !vc_busy_q[v]) begin
                free_found = 1'b1;
                free_vc    = VC_IDW'(v);
            end
        end
    end

    // Only registered grants are eligible, so a fresh grant waits one cycle.
    always_comb begin
        for (int unsigned i = 0; i < IN_N; i++) begin
            sa_cand[i] = grant_q[i] & data_vld_i[i] & (cred_q[id_q[i]] != '0);
        end
        sa_found = 1'b0;
        sa_win   = '0;
        for (int unsigned k = 0; k < IN_N; k++) begin
            if (!sa_found && sa_cand[rr_idx(sa_ptr_q, k)]) begin
                sa_found = 1'b1;
                sa_win   = rr_idx(sa_ptr_q, k);
            end
        end
        sel   = '0;
        sa_vc = '0;
        if (sa_found) begin
            sel[sa_win] = 1'b1;
            sa_vc       = id_q[sa_win];
        end
        for (int unsigned v = 0; v < VC_N; v++) begin
            xfer_vc[v] = sa_found && (sa_vc == VC_IDW'(v));
        end
    end

    always_comb begin
        grant_d   = grant_q;
        id_d      = id_q;
        vc_busy_d = vc_busy_q;
        va_ptr_d  = va_ptr_q;
        sa_ptr_d  = sa_ptr_q;
        if (sa_found) begin
            sa_ptr_d = ptr_inc(sa_win);
            if (flit_is_tail_i[sa_win]) begin
                vc_busy_d[sa_vc] = 1'b0;
                grant_d[sa_win]  = 1'b0;
                id_d[sa_win]     = '0;
            end
        end
        // Uses pre-edge busy state: a VC freed this cycle is not reused until next cycle.
        if (va_found && free_found) begin
            grant_d[va_win]    = 1'b1;
            id_d[va_win]       = free_vc;
            vc_busy_d[free_vc] = 1'b1;
            va_ptr_d           = ptr_inc(va_win);
        end
    end

    always_comb begin
        cred_d = cred_q;
        for (int unsigned v = 0; v < VC_N; v++) begin
            if (xfer_vc[v] && !credit_rtn_i[v] && cred_q[v] != '0) begin
                cred_d[v] = cred_q[v] - 1'b1;
            end else if (credit_rtn_i[v] && !xfer_vc[v] && cred_q[v] != CredMax) begin
                cred_d[v] = cred_q[v] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vc_busy_q <= '0;
            grant_q   <= '0;
            id_q      <= '0;
            cred_q    <= {VC_N{CredMax}};
            va_ptr_q  <= '0;
            sa_ptr_q  <= '0;
        end else begin
            vc_busy_q <= vc_busy_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            cred_q    <= cred_d;
            va_ptr_q  <= va_ptr_d;
            sa_ptr_q  <= sa_ptr_d;
        end
    end

`ifdef VC_ALLOC_CREDIT_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        for (int unsigned v = 0; v < VC_N; v++) begin
            if (credit_rtn_i[v] && !xfer_vc[v] && cred_q[v] == CredMax) err_d = 1'b1;
            if (xfer_vc[v] && cred_q[v] == '0) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign vc_grant_o   = grant_q;
    assign vc_id_o      = id_q;
    assign sel_o        = sel;
    assign oc_vld_o     = sa_found;
    assign oc_vc_o      = sa_vc;
    assign credit_cnt_o = cred_q;

endmodule

// File: tb/tb_vc_credit_allocator.sv
// Scenario bench for vc_credit_allocator (IN_N=5, VC_N=2, CREDIT_DEPTH=4).
module tb_vc_credit_allocator;

    logic       clk_i;
    logic       rst_ni;
    logic [4:0] req_i, data_vld_i, flit_is_tail_i;
    logic [1:0] credit_rtn_i;
    logic [4:0] vc_grant_o, vc_id_o, sel_o;
    logic       oc_vld_o;
    logic [0:0] oc_vc_o;
    logic [5:0] credit_cnt_o;
    logic       err_o;

    int nchk = 0;
    int nerr = 0;

`ifdef VC_ALLOC_CREDIT_CHECK_EN
    localparam logic ExpErr = 1'b1;
`else
    localparam logic ExpErr = 1'b0;
`endif

    typedef struct packed {
        logic [4:0] req, vld, tail;
        logic [1:0] rtn;
        logic [4:0] sel;
        logic       ovld;
        logic       ovc;
        logic [4:0] grant, vcid;
        logic [5:0] cred;
        logic       err;
    } row_t;

    row_t sb[$];

    vc_credit_allocator dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_i          (req_i),
        .data_vld_i     (data_vld_i),
        .flit_is_tail_i (flit_is_tail_i),
        .credit_rtn_i   (credit_rtn_i),
        .vc_grant_o     (vc_grant_o),
        .vc_id_o        (vc_id_o),
        .sel_o          (sel_o),
        .oc_vld_o       (oc_vld_o),
        .oc_vc_o        (oc_vc_o),
        .credit_cnt_o   (credit_cnt_o),
        .err_o          (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic row_t mk(logic [4:0] req, logic [4:0] vld, logic [4:0] tail,
                                logic [1:0] rtn, logic [4:0] sel, logic ovld, logic ovc,
                                logic [4:0] grant, logic [4:0] vcid, int c0, int c1,
                                logic err);
        row_t r;
        r.req = req; r.vld = vld; r.tail = tail; r.rtn = rtn;
        r.sel = sel; r.ovld = ovld; r.ovc = ovc;
        r.grant = grant; r.vcid = vcid; r.cred = {3'(c1), 3'(c0)}; r.err = err;
        return r;
    endfunction

    // Drives one cycle of stimulus and records what the DUT must show for it.
    task automatic apply_row(input row_t r);
        @(negedge clk_i);
        req_i          = r.req;
        data_vld_i     = r.vld;
        flit_is_tail_i = r.tail;
        credit_rtn_i   = r.rtn;
        sb.push_back(r);
    endtask

    task automatic clear_inputs();
        req_i = '0; data_vld_i = '0; flit_is_tail_i = '0; credit_rtn_i = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        nchk++;
        if ({vc_grant_o, vc_id_o, sel_o, oc_vld_o, oc_vc_o, err_o} !== 18'd0) begin
            nerr++;
            $display("FAIL reset_outputs: got grant=%b id=%b sel=%b vld=%b vc=%b err=%b want 0",
                     vc_grant_o, vc_id_o, sel_o, oc_vld_o, oc_vc_o, err_o);
        end
        rst_ni = 1'b1;
        #2;
        nchk++;
        if (credit_cnt_o !== {3'd4, 3'd4}) begin
            nerr++;
            $display("FAIL reset_credits: got %h want %h", credit_cnt_o, {3'd4, 3'd4});
        end
    endtask

    task automatic test_single_packet();
        row_t rows[$];
        row_t e;
        rows.push_back(mk(5'b00100, 5'b00100, 5'b00000, 2'b00, 5'b00000, 0, 0, 5'b00000, 5'b0, 4, 4, 0));
        rows.push_back(mk(5'b00000, 5'b00100, 5'b00000, 2'b00, 5'b00100, 1, 0, 5'b00100, 5'b0, 4, 4, 0));
        rows.push_back(mk(5'b00000, 5'b00100, 5'b00000, 2'b00, 5'b00100, 1, 0, 5'b00100, 5'b0, 3, 4, 0));
        rows.push_back(mk(5'b00000, 5'b00100, 5'b00100, 2'b00, 5'b00100, 1, 0, 5'b00100, 5'b0, 2, 4, 0));
        rows.push_back(mk(5'b00000, 5'b00000, 5'b00000, 2'b01, 5'b00000, 0, 0, 5'b00000, 5'b0, 1, 4, 0));
        rows.push_back(mk(5'b00000, 5'b00000, 5'b00000, 2'b01, 5'b00000, 0, 0, 5'b00000, 5'b0, 2, 4, 0));
        rows.push_back(mk(5'b00000, 5'b00000, 5'b00000, 2'b01, 5'b00000, 0, 0, 5'b00000, 5'b0, 3, 4, 0));
        // VC0 must be free again: input 0 gets VC0, not VC1.
        rows.push_back(mk(5'b00001, 5'b00001, 5'b00000, 2'b00, 5'b00000, 0, 0, 5'b00000, 5'b0, 4, 4, 0));
        rows.push_back(mk(5'b00000, 5'b00000, 5'b00000, 2'b00, 5'b00000, 0, 0, 5'b00001, 5'b0, 4, 4, 0));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            #2;
            e = sb.pop_front();
            nchk++;
            if ({sel_o, oc_vld_o, oc_vc_o} !== {e.sel, e.ovld, e.ovc}) begin
                nerr++;
                $display("FAIL single_pkt row%0d sw: got sel=%b vld=%b vc=%b want sel=%b vld=%b vc=%b",
                         i, sel_o, oc_vld_o, oc_vc_o, e.sel, e.ovld, e.ovc);
            end
            nchk++;
            if ({vc_grant_o, vc_id_o, credit_cnt_o, err_o} !== {e.grant, e.vcid, e.cred, e.err}) begin
                nerr++;
                $display("FAIL single_pkt row%0d st: got g=%b id=%b cr=%h err=%b want g=%b id=%b cr=%h err=%b",
                         i, vc_grant_o, vc_id_o, credit_cnt_o, err_o, e.grant, e.vcid, e.cred, e.err);
            end
        end
    endtask

    task automatic test_vc_contention();
        row_t rows[$];
        row_t e;
        rows.push_back(mk(5'b01011, 5'b01011, 5'b00000, 2'b00, 5'b00000, 0, 0, 5'b00000, 5'b00000, 4, 4, 0));
        rows.push_back(mk(5'b01010, 5'b01011, 5'b00000, 2'b00, 5'b00001, 1, 0, 5'b00001, 5'b00000, 4, 4, 0));
        rows.push_back(mk(5'b01000, 5'b01011, 5'b00000, 2'b00, 5'b00010, 1, 1, 5'b00011, 5'b00010, 3, 4, 0));
        rows.push_back(mk(5'b01000, 5'b01011, 5'b00001, 2'b00, 5'b00001, 1, 0, 5'b00011, 5'b00010, 3, 3, 0));
        rows.push_back(mk(5'b01000, 5'b01010, 5'b00000, 2'b00, 5'b00010, 1, 1, 5'b00010, 5'b00010, 2, 3, 0));
        rows.push_back(mk(5'b00000, 5'b01010, 5'b01000, 2'b00, 5'b01000, 1, 0, 5'b01010, 5'b00010, 2, 2, 0));
        rows.push_back(mk(5'b00000, 5'b00010, 5'b00010, 2'b00, 5'b00010, 1, 1, 5'b00010, 5'b00010, 1, 2, 0));
        rows.push_back(mk(5'b00000, 5'b00000, 5'b00000, 2'b00, 5'b00000, 0, 0, 5'b00000, 5'b00000, 1, 1, 0));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            #2;
            e = sb.pop_front();
            nchk++;
            if ({sel_o, oc_vld_o, oc_vc_o} !== {e.sel, e.ovld, e.ovc}) begin
                nerr++;
                $display("FAIL contention row%0d sw: got sel=%b vld=%b vc=%b want sel=%b vld=%b vc=%b",
                         i, sel_o, oc_vld_o, oc_vc_o, e.sel, e.ovld, e.ovc);
            end
            nchk++;
            if ({vc_grant_o, vc_id_o, credit_cnt_o, err_o} !== {e.grant, e.vcid, e.cred, e.err}) begin
                nerr++;
                $display("FAIL contention row%0d st: got g=%b id=%b cr=%h err=%b want g=%b id=%b cr=%h err=%b",
                         i, vc_grant_o, vc_id_o, credit_cnt_o, err_o, e.grant, e.vcid, e.cred, e.err);
            end
        end
    endtask

    task automatic test_round_robin();
        row_t rows[$];
        row_t e;
        rows.push_back(mk(5'b00011, 5'b00011, 5'b0, 2'b00, 5'b00000, 0, 0, 5'b00000, 5'b00000, 4, 4, 0));
        rows.push_back(mk(5'b00010, 5'b00011, 5'b0, 2'b00, 5'b00001, 1, 0, 5'b00001, 5'b00000, 4, 4, 0));
        rows.push_back(mk(5'b00000, 5'b00011, 5'b0, 2'b00, 5'b00010, 1, 1, 5'b00011, 5'b00010, 3, 4, 0));
        rows.push_back(mk(5'b00000, 5'b00011, 5'b0, 2'b00, 5'b00001, 1, 0, 5'b00011, 5'b00010, 3, 3, 0));
        rows.push_back(mk(5'b00000, 5'b00011, 5'b0, 2'b00, 5'b00010, 1, 1, 5'b00011, 5'b00010, 2, 3, 0));
        rows.push_back(mk(5'b00000, 5'b00011, 5'b0, 2'b00, 5'b00001, 1, 0, 5'b00011, 5'b00010, 2, 2, 0));
        rows.push_back(mk(5'b00000, 5'b00000, 5'b0, 2'b00, 5'b00000, 0, 0, 5'b00011, 5'b00010, 1, 2, 0));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            #2;
            e = sb.pop_front();
            nchk++;
            if ({sel_o, oc_vld_o, oc_vc_o} !== {e.sel, e.ovld, e.ovc}) begin
                nerr++;
                $display("FAIL round_robin row%0d sw: got sel=%b vld=%b vc=%b want sel=%b vld=%b vc=%b",
                         i, sel_o, oc_vld_o, oc_vc_o, e.sel, e.ovld, e.ovc);
            end
            nchk++;
            if ({vc_grant_o, vc_id_o, credit_cnt_o, err_o} !== {e.grant, e.vcid, e.cred, e.err}) begin
                nerr++;
                $display("FAIL round_robin row%0d st: got g=%b id=%b cr=%h err=%b want g=%b id=%b cr=%h err=%b",
                         i, vc_grant_o, vc_id_o, credit_cnt_o, err_o, e.grant, e.vcid, e.cred, e.err);
            end
        end
    endtask

    task automatic test_credit_block();
        row_t rows[$];
        row_t e;
        rows.push_back(mk(5'b10000, 5'b10000, 5'b0, 2'b00, 5'b00000, 0, 0, 5'b00000, 5'b00000, 4, 4, 0));
        rows.push_back(mk(5'b00000, 5'b10000, 5'b0, 2'b00, 5'b10000, 1, 0, 5'b10000, 5'b00000, 4, 4, 0));
        rows.push_back(mk(5'b00000, 5'b10000, 5'b0, 2'b00, 5'b10000, 1, 0, 5'b10000, 5'b00000, 3, 4, 0));
        rows.push_back(mk(5'b00000, 5'b10000, 5'b0, 2'b00, 5'b10000, 1, 0, 5'b10000, 5'b00000, 2, 4, 0));
        rows.push_back(mk(5'b00000, 5'b10000, 5'b0, 2'b00, 5'b10000, 1, 0, 5'b10000, 5'b00000, 1, 4, 0));
        rows.push_back(mk(5'b00100, 5'b10100, 5'b0, 2'b00, 5'b00000, 0, 0, 5'b10000, 5'b00000, 0, 4, 0));
        rows.push_back(mk(5'b00000, 5'b10100, 5'b0, 2'b01, 5'b00100, 1, 1, 5'b10100, 5'b00100, 0, 4, 0));
        rows.push_back(mk(5'b00000, 5'b10100, 5'b0, 2'b00, 5'b10000, 1, 0, 5'b10100, 5'b00100, 1, 3, 0));
        rows.push_back(mk(5'b00000, 5'b10100, 5'b0, 2'b00, 5'b00100, 1, 1, 5'b10100, 5'b00100, 0, 3, 0));
        rows.push_back(mk(5'b00000, 5'b10000, 5'b0, 2'b00, 5'b00000, 0, 0, 5'b10100, 5'b00100, 0, 2, 0));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            #2;
            e = sb.pop_front();
            nchk++;
            if ({sel_o, oc_vld_o, oc_vc_o} !== {e.sel, e.ovld, e.ovc}) begin
                nerr++;
                $display("FAIL credit_block row%0d sw: got sel=%b vld=%b vc=%b want sel=%b vld=%b vc=%b",
                         i, sel_o, oc_vld_o, oc_vc_o, e.sel, e.ovld, e.ovc);
            end
            nchk++;
            if ({vc_grant_o, vc_id_o, credit_cnt_o, err_o} !== {e.grant, e.vcid, e.cred, e.err}) begin
                nerr++;
                $display("FAIL credit_block row%0d st: got g=%b id=%b cr=%h err=%b want g=%b id=%b cr=%h err=%b",
                         i, vc_grant_o, vc_id_o, credit_cnt_o, err_o, e.grant, e.vcid, e.cred, e.err);
            end
        end
    endtask

    task automatic test_credit_return_err();
        row_t rows[$];
        row_t e;
        rows.push_back(mk(5'b00001, 5'b00001, 5'b0, 2'b00, 5'b00000, 0, 0, 5'b00000, 5'b0, 4, 4, 0));
        rows.push_back(mk(5'b00000, 5'b00001, 5'b0, 2'b01, 5'b00001, 1, 0, 5'b00001, 5'b0, 4, 4, 0));
        rows.push_back(mk(5'b00000, 5'b00000, 5'b0, 2'b00, 5'b00000, 0, 0, 5'b00001, 5'b0, 4, 4, 0));
        rows.push_back(mk(5'b00000, 5'b00000, 5'b0, 2'b01, 5'b00000, 0, 0, 5'b00001, 5'b0, 4, 4, 0));
        rows.push_back(mk(5'b00000, 5'b00000, 5'b0, 2'b00, 5'b00000, 0, 0, 5'b00001, 5'b0, 4, 4, ExpErr));
        rows.push_back(mk(5'b00000, 5'b00000, 5'b0, 2'b00, 5'b00000, 0, 0, 5'b00001, 5'b0, 4, 4, ExpErr));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            #2;
            e = sb.pop_front();
            nchk++;
            if ({sel_o, oc_vld_o, oc_vc_o} !== {e.sel, e.ovld, e.ovc}) begin
                nerr++;
                $display("FAIL credit_err row%0d sw: got sel=%b vld=%b vc=%b want sel=%b vld=%b vc=%b",
                         i, sel_o, oc_vld_o, oc_vc_o, e.sel, e.ovld, e.ovc);
            end
            nchk++;
            if ({vc_grant_o, vc_id_o, credit_cnt_o, err_o} !== {e.grant, e.vcid, e.cred, e.err}) begin
                nerr++;
                $display("FAIL credit_err row%0d st: got g=%b id=%b cr=%h err=%b want g=%b id=%b cr=%h err=%b",
                         i, vc_grant_o, vc_id_o, credit_cnt_o, err_o, e.grant, e.vcid, e.cred, e.err);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        row_t rows[$];
        row_t e;
        rows.push_back(mk(5'b00010, 5'b00010, 5'b0, 2'b00, 5'b00000, 0, 0, 5'b00000, 5'b0, 4, 4, 0));
        rows.push_back(mk(5'b00000, 5'b00010, 5'b0, 2'b00, 5'b00010, 1, 0, 5'b00010, 5'b0, 4, 4, 0));
        rows.push_back(mk(5'b00000, 5'b00010, 5'b0, 2'b00, 5'b00010, 1, 0, 5'b00010, 5'b0, 3, 4, 0));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            #2;
            e = sb.pop_front();
            nchk++;
            if ({sel_o, oc_vld_o, oc_vc_o} !== {e.sel, e.ovld, e.ovc}) begin
                nerr++;
                $display("FAIL mid_reset row%0d sw: got sel=%b vld=%b vc=%b want sel=%b vld=%b vc=%b",
                         i, sel_o, oc_vld_o, oc_vc_o, e.sel, e.ovld, e.ovc);
            end
            nchk++;
            if ({vc_grant_o, vc_id_o, credit_cnt_o, err_o} !== {e.grant, e.vcid, e.cred, e.err}) begin
                nerr++;
                $display("FAIL mid_reset row%0d st: got g=%b id=%b cr=%h err=%b want g=%b id=%b cr=%h err=%b",
                         i, vc_grant_o, vc_id_o, credit_cnt_o, err_o, e.grant, e.vcid, e.cred, e.err);
            end
        end
        // Asynchronous reset between clock edges, inputs still active.
        #1 rst_ni = 1'b0;
        #1;
        nchk++;
        if ({vc_grant_o, vc_id_o, sel_o, oc_vld_o, oc_vc_o, err_o} !== 18'd0) begin
            nerr++;
            $display("FAIL mid_reset_async: got grant=%b id=%b sel=%b vld=%b vc=%b err=%b want 0",
                     vc_grant_o, vc_id_o, sel_o, oc_vld_o, oc_vc_o, err_o);
        end
        @(negedge clk_i);
        clear_inputs();
        rst_ni = 1'b1;
        #2;
        nchk++;
        if ({vc_grant_o, credit_cnt_o} !== {5'b00000, 3'd4, 3'd4}) begin
            nerr++;
            $display("FAIL mid_reset_release: got grant=%b cr=%h want grant=00000 cr=%h",
                     vc_grant_o, credit_cnt_o, {3'd4, 3'd4});
        end
    endtask

    initial begin
        clear_inputs();
        rst_ni = 1'b0;
        test_reset();
        test_single_packet();
        test_reset();
        test_vc_contention();
        test_reset();
        test_round_robin();
        test_reset();
        test_credit_block();
        test_reset();
        test_credit_return_err();
        test_reset();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
